// File: rtl/uart_seg7_pkg.sv
// Shared types, constants and helpers for the serial/display I/O block.
package uart_seg7_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Active-high segments: bit0=a .. bit6=g, bit7=dp (always off)
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic int unsigned calc_bit_div(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_seg7_io_hex_seg_decoder.sv
// Combinational hex digit to 7-segment pattern lookup.
module hex_seg_decoder
  import uart_seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/uart_seg7_io.sv
// 8N1 UART receiver and transmitter plus a dual hex-digit 7-segment decoder,
// all in the clk domain; rxd is synchronized before use.
module uart_seg7_io
  import uart_seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 11059200,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_frame_err,
  output logic       txd,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  input  logic [7:0] seg_value,
  output logic [7:0] seg_lo,
  output logic [7:0] seg_hi
);

  localparam int unsigned BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);
  localparam int unsigned CW      = $clog2(BIT_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);

  if (BIT_DIV < 8) begin : g_bit_div_check
    $error("uart_seg7_io: BIT_DIV must be >= 8");
  end

  uart_state_t       tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [2:0]        tx_bit;
  logic [7:0]        tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: if (tx_start) begin
          tx_shift <= tx_data;
          tx_cnt   <= '0;
          txd      <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= START;
        end
        START: if (tx_cnt == DIV_LAST) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          txd      <= tx_shift[0];
          tx_state <= DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        DATA: if (tx_cnt == DIV_LAST) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) begin
            txd      <= 1'b1;
            tx_state <= STOP;
          end else txd <= tx_shift[1];
        end else tx_cnt <= tx_cnt + 1'b1;
        // A held request chains straight into the next start bit
        STOP: if (tx_cnt == DIV_LAST) begin
          tx_cnt <= '0;
          if (tx_start) begin
            tx_shift <= tx_data;
            txd      <= 1'b0;
            tx_state <= START;
          end else begin
            tx_busy  <= 1'b0;
            tx_state <= IDLE;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_state_t       rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              rx_s1, rx_s2, rx_prev;

  // Start detection needs rx_prev high, so a line held low after a bad
  // stop bit cannot re-arm the receiver until it has returned high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= rxd;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        IDLE: if (rx_prev && !rx_s2) begin
          rx_cnt   <= '0;
          rx_state <= START;
        end
        START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        DATA: if (rx_cnt == DIV_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        STOP: if (rx_cnt == DIV_LAST) begin
          rx_cnt <= '0;
          if (rx_s2) begin
            rx_data  <= rx_shift;
            rx_ready <= 1'b1;
          end else rx_frame_err <= 1'b1;
          rx_state <= IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= IDLE;
      endcase
    end
  end

  hex_seg_decoder u_seg_lo (.hex(seg_value[3:0]), .seg(seg_lo));
  hex_seg_decoder u_seg_hi (.hex(seg_value[7:4]), .seg(seg_hi));

endmodule

// File: tb/tb_uart_seg7_io.sv
// Randomized self-checking bench for uart_seg7_io at BIT_DIV=16.
module tb_uart_seg7_io;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] seg_value = '0;
  logic       rxd, txd, tx_busy, rx_ready, rx_frame_err;
  logic [7:0] rx_data, seg_lo, seg_hi;

  int checks = 0, failures = 0, cyc = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] rdy_q[$];
  int         rdy_t[$];
  logic [7:0] exp_rx = 8'h00;
  logic [7:0] seg_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  assign rxd = loop_en ? txd : rxd_drv;

  uart_seg7_io #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .txd(txd), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .seg_value(seg_value), .seg_lo(seg_lo), .seg_hi(seg_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_ready) begin
      rdy_q.push_back(rx_data);
      rdy_t.push_back(cyc);
    end
    if (rx_frame_err) err_cnt++;
    if (rx_ready && rx_frame_err) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      tick(BD);
    end
    rxd_drv = 1'b1;
  endtask

  // Expected line level is the 10-bit frame read one slot per BD cycles.
  task automatic tx_frame_check(input logic [7:0] d, input logic poke);
    logic [9:0] fr;
    logic       lvl;
    fr = {1'b1, d, 1'b0};
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    for (int k = 0; k < 340; k++) begin
      if (poke && k == 40) tx_start = 1'b1;
      if (k == 41) tx_start = 1'b0;
      lvl = (k < 10 * BD) ? fr[k / BD] : 1'b1;
      check_eq("txd", {31'd0, txd}, {31'd0, lvl});
      check_eq("tx_busy", {31'd0, tx_busy}, (k < 10 * BD) ? 1 : 0);
      tick(1);
    end
  endtask

  task automatic rx_frame_check(input logic [7:0] d);
    int n0, e0, t0, lat;
    n0 = rdy_q.size();
    e0 = err_cnt;
    t0 = cyc;
    drive_rx(d, 1'b1);
    tick(20);
    check_eq("rx_ready_count", rdy_q.size() - n0, 1);
    check_eq("rx_err_count", err_cnt - e0, 0);
    if (rdy_q.size() > n0) begin
      lat = rdy_t[n0] - t0;
      check_eq("rx_byte", {24'd0, rdy_q[n0]}, {24'd0, d});
      check_eq("rx_latency_window", (lat >= 153 && lat <= 157) ? 1 : 0, 1);
    end
    check_eq("rx_data_hold", {24'd0, rx_data}, {24'd0, d});
    exp_rx = d;
  endtask

  initial begin
    int n0, e0;
    logic [7:0] d;

    tick(3);
    check_eq("rst_txd", {31'd0, txd}, 1);
    check_eq("rst_tx_busy", {31'd0, tx_busy}, 0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 0);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 0);
    check_eq("rst_rx_frame_err", {31'd0, rx_frame_err}, 0);
    rst_n = 1'b1;
    tick(5);

    tx_frame_check(8'hA5, 1'b1);
    for (int i = 0; i < 2; i++) tx_frame_check(8'($urandom), 1'($urandom));

    for (int i = 0; i < 4; i++) rx_frame_check(8'($urandom));
    rx_frame_check(8'h3C);

    n0 = rdy_q.size();
    e0 = err_cnt;
    rxd_drv = 1'b0;
    tick(4);
    rxd_drv = 1'b1;
    tick(40);
    check_eq("glitch_no_ready", rdy_q.size() - n0, 0);
    check_eq("glitch_no_err", err_cnt - e0, 0);

    d = 8'($urandom);
    drive_rx(d, 1'b0);
    rxd_drv = 1'b0;
    tick(40);
    rxd_drv = 1'b1;
    tick(20);
    check_eq("ferr_pulse_count", err_cnt - e0, 1);
    check_eq("ferr_no_ready", rdy_q.size() - n0, 0);
    check_eq("ferr_rx_data_kept", {24'd0, rx_data}, {24'd0, exp_rx});
    rx_frame_check(8'($urandom));

    n0 = rdy_q.size();
    loop_en = 1'b1;
    tick(2);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    tick(1);
    tx_data = 8'hFF;
    tick(10 * BD);
    tx_data = 8'h55;
    tick(10 * BD);
    tx_start = 1'b0;
    tick(400);
    check_eq("loop_count", rdy_q.size() - n0, 3);
    if (rdy_q.size() >= n0 + 3) begin
      check_eq("loop_b0", {24'd0, rdy_q[n0]}, 32'h00);
      check_eq("loop_b1", {24'd0, rdy_q[n0 + 1]}, 32'hFF);
      check_eq("loop_b2", {24'd0, rdy_q[n0 + 2]}, 32'h55);
      check_eq("loop_gap1", rdy_t[n0 + 1] - rdy_t[n0], 10 * BD);
      check_eq("loop_gap2", rdy_t[n0 + 2] - rdy_t[n0 + 1], 10 * BD);
    end
    loop_en = 1'b0;
    exp_rx = 8'h55;
    check_eq("loop_rx_data", {24'd0, rx_data}, {24'd0, exp_rx});

    rxd_drv  = 1'b0;
    tx_data  = 8'($urandom);
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(50);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_txd", {31'd0, txd}, 1);
    check_eq("midrst_tx_busy", {31'd0, tx_busy}, 0);
    check_eq("midrst_rx_data", {24'd0, rx_data}, 0);
    check_eq("midrst_rx_ready", {31'd0, rx_ready}, 0);
    rxd_drv = 1'b1;
    @(negedge clk);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    exp_rx = 8'h00;
    tx_frame_check(8'($urandom), 1'b0);
    rx_frame_check(8'($urandom));

    for (int v = 0; v < 256; v++) begin
      seg_value = v[7:0];
      #1;
      check_eq("seg_lo", {24'd0, seg_lo}, {24'd0, seg_ref[v % 16]});
      check_eq("seg_hi", {24'd0, seg_hi}, {24'd0, seg_ref[v / 16]});
    end

    check_eq("ready_err_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_seg7_io.md
Name: uart_seg7_io

Overview:
- Board-level serial and display I/O block: an 8N1 UART receiver, an 8N1 UART transmitter and a dual hex-digit 7-segment decoder.
- The CPU top level uses it to drive the external serial port at 115200 baud from the 11.0592 MHz UART clock.
- The same block shows a byte on the two 7-segment digits.
- Everything runs in a single clock domain; rxd is the only asynchronous input.

Parameters:
- CLK_FREQ, 11059200: clk frequency in Hz.
- BAUD, 115200: serial bit rate.
- BIT_DIV, (CLK_FREQ+BAUD/2)/BAUD = 96: clk cycles per bit. Derived, not overridable. Must be >= 8; elaborate-time error otherwise.

Ports:
- clk  in  1  UART clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, idle high, asynchronous.
- rx_data  out  8  last correctly framed received byte.
- rx_ready  out  1  one-cycle pulse when rx_data is updated.
- rx_frame_err  out  1  one-cycle pulse when a frame's stop bit is sampled low.
- txd  out  1  serial output, idle high.
- tx_start  in  1  request to send tx_data; level-sampled each cycle.
- tx_data  in  8  byte to send; captured in the cycle tx_start is accepted.
- tx_busy  out  1  high while a frame is in flight.
- seg_value  in  8  byte to display.
- seg_lo  out  8  segment pattern for seg_value[3:0].
- seg_hi  out  8  segment pattern for seg_value[7:4].

Behaviour:
- Reset (asynchronous, rst_n=0):
  - txd=1, tx_busy=0.
  - rx_data=0, rx_ready=0, rx_frame_err=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately; txd returns high.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- Transmitter FSM, states IDLE -> START -> DATA (8 bits) -> STOP -> IDLE:
  - In IDLE with tx_start=1: latch tx_data and go to START. From the next cycle, tx_busy=1 and txd=0.
  - Each state or bit holds for exactly BIT_DIV cycles.
  - After the stop bit, tx_busy=0 and the FSM returns to IDLE.
  - Total frame is 10*BIT_DIV cycles.
  - tx_start while busy is ignored; no queueing.
  - tx_start held high sends back-to-back frames with no idle gap.
- Receiver:
  - rxd passes through a 2-flop synchronizer before use.
  - IDLE: a synchronized high-to-low transition enters START.
  - START: at BIT_DIV/2 cycles, resample. If high, it is a glitch; return to IDLE with no output. If low, go to DATA.
  - DATA: sample one bit every BIT_DIV cycles (mid-bit), shifting LSB first.
  - STOP: sample at mid-bit.
    - High: rx_data <= shifted byte and rx_ready=1 for one cycle.
    - Low: rx_frame_err=1 for one cycle; rx_data unchanged.
  - Either way, wait until rxd is high before re-arming IDLE, so a break does not retrigger.
  - rx_ready and rx_frame_err are never high together.
  - rx_data holds its value between frames.
- Receiver and transmitter are fully independent; simultaneous rx and tx are legal.
- Segment decoder:
  - Purely combinational, zero latency.
  - Bit order: bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g, 7=dp. Active high; dp is always 0.
  - Codes 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

Decomposition:
- Package uart_seg7_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP), shared by rx and tx;
  - the 16-entry segment constant table;
  - a function computing BIT_DIV from CLK_FREQ and BAUD.
- One natural sub-module: hex_seg_decoder (4-bit in, 8-bit out), instantiated twice.
- Rx and tx stay in the top as two always-blocks with their own bit counters.

Test Plan (sim with CLK_FREQ=1600, BAUD=100, so BIT_DIV=16):
1. Tx 0xA5:
   - Stimulus: pulse tx_start with tx_data=0xA5.
   - Required: txd levels per 16-cycle slot are 0,1,0,1,0,0,1,0,1,1. tx_busy is high for exactly 160 cycles.
   - Required: a tx_start pulse mid-frame produces no second frame.
2. Rx 0x3C:
   - Stimulus: drive a well-formed 0x3C frame on rxd.
   - Required: rx_ready pulses once, 1 cycle wide, about 2+8+9*16 cycles after the start edge. rx_data=0x3C; rx_frame_err stays 0.
3. Glitch and framing error:
   - Stimulus: a 4-cycle low glitch on rxd. Required: no rx_ready and no rx_frame_err.
   - Stimulus: a frame with stop bit 0. Required: rx_frame_err pulses once and rx_data retains its previous 0x3C.
4. Loopback:
   - Stimulus: txd tied to rxd; send 0x00, 0xFF, 0x55 back-to-back with tx_start held high.
   - Required: three rx_ready pulses with matching rx_data, with 160 cycles between pulses.
5. Reset:
   - Stimulus: assert rst_n=0 mid tx/rx frame.
   - Required: outputs go immediately to txd=1, tx_busy=0, rx_data=0. After release, the next frame works normally.
6. Segment table:
   - Stimulus: sweep seg_value over 0x00 to 0xFF.
   - Required: seg_lo and seg_hi match the table, e.g. 0x8F gives seg_hi=7F and seg_lo=71; 0x10 gives seg_hi=06 and seg_lo=3F.
